// File: rtl/ex_mem_stage_param.sv
// Execute stage with EX/MEM output register: forwarding, ALU, branch resolution
// and an optional one-bit-per-cycle shift-add multiplier.
module ex_mem_stage_param #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned MUL_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            mem_stall,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic [3:0]      op,
  input  logic            alusrc,
  input  logic            is_branch,
  input  logic            regwrite,
  input  logic            memread,
  input  logic            memwrite,
  input  logic            memtoreg,
  input  logic [2:0]      funct3,
  input  logic [4:0]      wb_rd,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store,
  output logic [4:0]      out_rd,
  output logic            out_regwrite,
  output logic            out_memread,
  output logic            out_memwrite,
  output logic            out_memtoreg,
  output logic [2:0]      out_funct3,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            busy
);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = $clog2(XLEN + 1);

  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t state, state_nx;

  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_y;
  logic [SHW-1:0]  shamt;
  logic            br_cond;
  logic            fire, start_mul, mul_last;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mul_acc, mul_mcand, mul_mplier, mul_store, mul_acc_nx;
  logic [4:0]      mul_rd;
  logic            mul_regwrite, mul_memread, mul_memwrite, mul_memtoreg;
  logic [2:0]      mul_funct3;

  // Operand forwarding: EX/MEM register beats MEM/WB, x0 is never forwarded
  always_comb begin
    fwd_a = rs1_data;
    if (rs1_addr != 5'd0 && out_valid && out_regwrite && out_rd == rs1_addr)
      fwd_a = out_result;
    else if (rs1_addr != 5'd0 && wb_regwrite && wb_rd == rs1_addr)
      fwd_a = wb_data;
    fwd_b = rs2_data;
    if (rs2_addr != 5'd0 && out_valid && out_regwrite && out_rd == rs2_addr)
      fwd_b = out_result;
    else if (rs2_addr != 5'd0 && wb_regwrite && wb_rd == rs2_addr)
      fwd_b = wb_data;
  end

  assign alu_b = alusrc ? imm : fwd_b;
  assign shamt = alu_b[SHW-1:0];

  always_comb begin
    alu_y = fwd_a + alu_b;
    case (op)
      OP_SUB:   alu_y = fwd_a - alu_b;
      OP_AND:   alu_y = fwd_a & alu_b;
      OP_OR:    alu_y = fwd_a | alu_b;
      OP_XOR:   alu_y = fwd_a ^ alu_b;
      OP_SLL:   alu_y = fwd_a << shamt;
      OP_SRL:   alu_y = fwd_a >> shamt;
      OP_SRA:   alu_y = $unsigned($signed(fwd_a) >>> shamt);
      OP_SLT:   alu_y = XLEN'($signed(fwd_a) < $signed(alu_b));
      OP_SLTU:  alu_y = XLEN'(fwd_a < alu_b);
      OP_PASSB: alu_y = alu_b;
      default:  alu_y = fwd_a + alu_b;
    endcase
  end

  // Branch compare uses the register operands, never the immediate
  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      3'b000:  br_cond = (fwd_a == fwd_b);
      3'b001:  br_cond = (fwd_a != fwd_b);
      3'b100:  br_cond = ($signed(fwd_a) < $signed(fwd_b));
      3'b101:  br_cond = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  br_cond = (fwd_a < fwd_b);
      3'b111:  br_cond = (fwd_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign fire       = in_valid & in_ready & ~flush;
  assign start_mul  = fire & (op == OP_MUL) & (MUL_EN != 0);
  assign mul_last   = (state == S_MUL) & ~mem_stall & (cnt == CW'(XLEN - 1));
  assign mul_acc_nx = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_mul) state_nx = S_MUL;
        S_MUL:   if (mul_last) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state == S_MUL);
    in_ready = (state == S_IDLE) & ~mem_stall;
  end

  // Multiplier datapath: operands and write-back fields captured at acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      mul_acc      <= '0;
      mul_mcand    <= '0;
      mul_mplier   <= '0;
      mul_store    <= '0;
      mul_rd       <= '0;
      mul_regwrite <= 1'b0;
      mul_memread  <= 1'b0;
      mul_memwrite <= 1'b0;
      mul_memtoreg <= 1'b0;
      mul_funct3   <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (start_mul) begin
      cnt          <= '0;
      mul_acc      <= '0;
      mul_mcand    <= fwd_a;
      mul_mplier   <= alu_b;
      mul_store    <= fwd_b;
      mul_rd       <= rd_addr;
      mul_regwrite <= regwrite & ~is_branch;
      mul_memread  <= memread;
      mul_memwrite <= memwrite;
      mul_memtoreg <= memtoreg;
      mul_funct3   <= funct3;
    end else if (state == S_MUL && !mem_stall) begin
      mul_acc    <= mul_acc_nx;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      cnt        <= mul_last ? '0 : cnt + CW'(1);
    end
  end

  // EX/MEM output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_store    <= '0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
      out_memread  <= 1'b0;
      out_memwrite <= 1'b0;
      out_memtoreg <= 1'b0;
      out_funct3   <= '0;
      br_taken     <= 1'b0;
      br_target    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      br_taken  <= 1'b0;
    end else if (!mem_stall) begin
      if (mul_last) begin
        out_valid    <= 1'b1;
        out_result   <= mul_acc_nx;
        out_store    <= mul_store;
        out_rd       <= mul_rd;
        out_regwrite <= mul_regwrite;
        out_memread  <= mul_memread;
        out_memwrite <= mul_memwrite;
        out_memtoreg <= mul_memtoreg;
        out_funct3   <= mul_funct3;
        br_taken     <= 1'b0;
      end else if (fire && !start_mul) begin
        out_valid    <= 1'b1;
        out_result   <= alu_y;
        out_store    <= fwd_b;
        out_rd       <= rd_addr;
        out_regwrite <= regwrite & ~is_branch;
        out_memread  <= memread;
        out_memwrite <= memwrite;
        out_memtoreg <= memtoreg;
        out_funct3   <= funct3;
        br_taken     <= is_branch & br_cond;
        if (is_branch) br_target <= pc + imm;
      end else begin
        out_valid <= 1'b0;
        br_taken  <= 1'b0;
      end
    end
  end
endmodule

// File: doc/ex_mem_stage_param.md
EX_MEM_STAGE_PARAM -- requirements
Module: ex_mem_stage_param

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter MUL_EN, default 1, enables the iterative multiply unit (0: MUL executes as ADD).
REQ-003 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have in_valid / in_ready  input / output  1 / 1  ID/EX issue handshake; transfer when both high at a clock edge.
REQ-006 SHALL have flush  input  1  kills the op in the stage and the output register.
REQ-007 SHALL have mem_stall  input  1  downstream hold; output register frozen.
REQ-008 SHALL have rs1_data, rs2_data, imm, pc  input  XLEN each  operands, immediate, instruction PC.
REQ-009 SHALL have rs1_addr, rs2_addr, rd_addr  input  5 each  register indices.
REQ-010 SHALL have op  input  4  ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9 PASSB=10 MUL=11, others treated as ADD.
REQ-011 SHALL have alusrc, is_branch, regwrite, memread, memwrite, memtoreg  input  1 each; funct3 input 3.
REQ-012 SHALL have wb_rd, wb_regwrite, wb_data  input  5/1/XLEN  MEM/WB forwarding source.
REQ-013 SHALL have out_valid, out_result, out_store, out_rd, out_regwrite, out_memread, out_memwrite, out_memtoreg, out_funct3  output  registered EX/MEM fields.
REQ-014 SHALL have br_taken, br_target  output  1/XLEN  registered branch resolution; busy  output  1  multiply in progress.

Function
REQ-015 Operand A SHALL be out_result when out_valid & out_regwrite & out_rd==rs1_addr & rs1_addr!=0, else wb_data when wb_regwrite & wb_rd==rs1_addr & rs1_addr!=0, else rs1_data; operand B (pre-alusrc) and out_store likewise from rs2.
REQ-016 EX/MEM forwarding SHALL take priority over MEM/WB; index 0 never forwarded.
REQ-017 ALU B input SHALL be imm when alusrc=1, else forwarded rs2; shifts SHALL use B[log2(XLEN)-1:0]; SLT/SLTU result zero-extended 0/1.
REQ-018 Non-MUL ops SHALL have latency 1: accepted at edge N, out_valid=1 after edge N.
REQ-019 is_branch SHALL resolve on forwarded A vs forwarded B (not imm) per funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU, others not taken; br_target = pc + imm mod 2^XLEN.
REQ-020 br_taken SHALL be a one-cycle pulse registered with the op; is_branch ops SHALL write out_regwrite=0 regardless of input.
REQ-021 FSM states IDLE, MUL: IDLE->MUL when MUL accepted with MUL_EN=1; MUL->IDLE after XLEN iterations (shift-add, one bit per cycle) with low XLEN bits of product loaded to output register; operands latched at acceptance.
REQ-022 MUL latency SHALL be XLEN+1 edges from acceptance to out_valid; out_valid=0 during iterations.
REQ-023 busy=1 in MUL; in_ready = !busy & !mem_stall.
REQ-024 mem_stall=1 SHALL hold all out_* and br_* unchanged and pause the MUL counter.
REQ-025 flush SHALL win over all: next edge out_valid=0, br_taken=0, FSM->IDLE, counter cleared, no op accepted that edge.
REQ-026 flush and mem_stall together SHALL flush.
REQ-027 Edge with no transfer and no stall SHALL set out_valid=0, br_taken=0 (bubble).

Reset
REQ-028 rst low SHALL immediately force FSM IDLE, counter 0, out_valid 0, br_taken 0, busy 0, all out_* data/index/control 0, br_target 0.
REQ-029 rst deassertion mid-multiply SHALL leave no residual op; first accept after reset starts cleanly.

Verification
REQ-030 ADD rs1=5,rs2=7,rd=3 -> next cycle out_valid=1, out_result=12, out_rd=3.
REQ-031 back-to-back: x3=12 result, then ADD rs1=x3,rs2=x3 with rs1_data=0 -> out_result=24 (EX/MEM forward); same with wb_rd=3,wb_data=9 and no EX/MEM match -> 18.
REQ-032 MUL 6*7, XLEN=32 -> busy 32 cycles, in_ready=0, out_valid after 33 edges, out_result=42; flush at cycle 10 -> out_valid never set, busy=0 next cycle.
REQ-033 BLT pc=0x100, imm=0x20, A=-1, B=1 -> br_taken=1, br_target=0x120, out_regwrite=0; BLTU same operands -> br_taken=0.
REQ-034 mem_stall held 3 cycles after SUB 9-4 -> out_result=5 stable, in_ready=0; rst low asynchronously mid-stall -> all outputs 0 before next edge.
